// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction fetch stage.
// Holds the PC and issues one-outstanding fetch requests. Returned instructions are
// presented to decode through a stallable output register that is backed by a
// one-entry skid buffer. Later stages can redirect the stage, which flushes it.
// Optional feature: define IFU_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [10:0]       if_opcode
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;   // address of the outstanding request

  logic              if_valid_q;
  logic [31:0]       if_instr_q;
  logic [ADDR_W-1:0] if_pc_q;

  logic              skid_valid_q;
  logic [31:0]       skid_instr_q;
  logic [ADDR_W-1:0] skid_pc_q;

  logic              slot_free;
  logic              req_raw;
  logic              rsp_take;

  // A new request may only go out when its response is guaranteed a home.
  assign slot_free = !skid_valid_q && (!if_valid_q || !stall);

  // Next-state, PC update and request generation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_raw  = 1'b0;
    rsp_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        // rvalid here is a protocol error and is ignored.
        if (!redirect && slot_free) begin
          req_raw = 1'b1;
        end
      end
      StWait: begin
        if (redirect) begin
          state_d = imem_rvalid ? StIdle : StDrop;
        end else if (imem_rvalid) begin
          rsp_take = 1'b1;
          if (slot_free) begin
            req_raw = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        // The flushed response is discarded whenever it shows up.
        if (imem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (req_raw) begin
      pc_d     = pc_q + ADDR_W'(4);
      req_pc_d = pc_q;
      state_d  = StWait;
    end
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end
  end

  // FSM, PC and outstanding-address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Output register and skid buffer; the skid always drains before a new response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (redirect) begin
      if_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!stall) begin
      if (skid_valid_q) begin
        if_valid_q   <= 1'b1;
        if_instr_q   <= skid_instr_q;
        if_pc_q      <= skid_pc_q;
        skid_valid_q <= 1'b0;
      end else if (rsp_take) begin
        if_valid_q <= 1'b1;
        if_instr_q <= imem_rdata;
        if_pc_q    <= req_pc_q;
      end else begin
        if_valid_q <= 1'b0;
      end
    end else if (rsp_take) begin
      // Stalled: an empty output register still accepts, otherwise park in the skid.
      if (!if_valid_q) begin
        if_valid_q <= 1'b1;
        if_instr_q <= imem_rdata;
        if_pc_q    <= req_pc_q;
      end else begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= imem_rdata;
        skid_pc_q    <= req_pc_q;
      end
    end
  end

  // Request is forced low while reset is asserted.
  assign imem_req  = req_raw & reset_n;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_opcode = if_instr_q[31:21];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Free-running event counters; redirect does not clear them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (rsp_take) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (if_valid_q && stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized stream
// checked against an in-order program-stream model. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [10:0] if_opcode;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state.
  int          mem_lat   = 1;   // 0 = random 1..3 cycles
  int          mem_quota = -1;  // negative = unlimited responses
  int          mem_served = 0;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  int          proto_err = 0;

  instr_fetch_unit #(
    .ADDR_W  (64),
    .RESET_PC(64'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_opcode  (if_opcode)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Program image: address 0 holds the reference instruction, everything else a hash.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // Instruction memory: one outstanding request, response after mem_lat cycles.
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      mem_pend    = 1'b0;
      mem_served  = 0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt > 1) begin
          mem_cnt--;
        end else if (mem_quota < 0 || mem_served < mem_quota) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_pend    = 1'b0;
          mem_served++;
        end
      end
    end
    @(negedge clk);
    if (reset_n && imem_req) begin
      if (mem_pend) proto_err++;
      mem_pend = 1'b1;
      mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      mem_addr = imem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    step();
    reset_n  = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) step();
  endtask

  // Ends 1ns into cycle 0 after reset release.
  task automatic release_reset();
    step();
    reset_n  = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    hold_reset();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req);
    end
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== 97'h0) begin
      n_fail++; $display("FAIL reset_if got v=%b pc=%h i=%h exp 0/0/0", if_valid, if_pc, if_instr);
    end
    release_reset();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_fail++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_opcode !== 11'h458 || if_instr !== 32'h8B020020) begin
      n_fail++;
      $display("FAIL first_instr got v=%b pc=%h op=%h i=%h exp v=1 pc=0 op=458 i=8b020020",
               if_valid, if_pc, if_opcode, if_instr);
    end
  endtask

  task automatic test_stall_skid();
    logic [63:0] seen[$];
    mem_lat = 1;
    hold_reset();
    release_reset();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      stall = (c >= 3 && c <= 5);
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 64'h4 || imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d got v=%b pc=%h req=%b exp v=1 pc=4 req=0",
                   c, if_valid, if_pc, imem_req);
        end
      end else if (if_valid) begin
        seen.push_back(if_pc);
      end
    end
    step();
    stall = 1'b0;
    n_checks++;
    if (seen.size() < 4) begin
      n_fail++; $display("FAIL stream_count got=%0d exp>=4", seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (seen[k] !== 64'(4 * k)) begin
          n_fail++; $display("FAIL stream_order k=%0d got=%h exp=%h", k, seen[k], 64'(4 * k));
        end
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    bit found = 0;
    mem_lat = 2;
    hold_reset();
    release_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 64'h10) begin found = 1; break; end
      step();
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL redir_find_req got=none exp=req@10");
    end
    step();
    redirect = 1'b1;
    redirect_pc = 64'h103;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_req_low got=%b exp=0", imem_req);
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush got v=%b exp=0", if_valid);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin step(); @(negedge clk); end
      if (if_valid) begin
        n_checks++;
        n_fail++; $display("FAIL redir_stale got pc=%h exp no valid before refetch", if_pc);
      end
      if (imem_req) begin found = 1; break; end
    end
    n_checks++;
    if (!found || imem_addr !== 64'h100) begin
      n_fail++; $display("FAIL redir_addr got found=%0d addr=%h exp addr=100", found, imem_addr);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (if_valid) begin found = 1; break; end
    end
    n_checks++;
    if (!found || if_pc !== 64'h100 || if_instr !== mem_word(64'h100)) begin
      n_fail++; $display("FAIL redir_first got found=%0d pc=%h exp pc=100", found, if_pc);
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found = 0;
    mem_lat = 1;
    hold_reset();
    release_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 64'h8) begin found = 1; break; end
      step();
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rr_find_req got=none exp=req@8");
    end
    step();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h200;
    @(negedge clk);
    n_checks++;
    if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rr_same_cycle got rvalid=%b req=%b exp rvalid=1 req=0",
                         imem_rvalid, imem_req);
    end
    step();
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      n_fail++; $display("FAIL rr_after got v=%b req=%b addr=%h exp v=0 req=1 addr=200",
                         if_valid, imem_req, imem_addr);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (if_valid) begin found = 1; break; end
    end
    n_checks++;
    if (!found || if_pc !== 64'h200) begin
      n_fail++; $display("FAIL rr_first got found=%0d pc=%h exp pc=200", found, if_pc);
    end
  endtask

  task automatic test_pc_wrap();
    bit found = 0;
    mem_lat = 1;
    step();
    redirect = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) begin found = 1; break; end
      step();
    end
    n_checks++;
    if (!found || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top got found=%0d addr=%h exp fffffffffffffffc", found, imem_addr);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (imem_req) begin found = 1; break; end
    end
    n_checks++;
    if (!found || imem_addr !== 64'h0) begin
      n_fail++; $display("FAIL wrap_next got found=%0d addr=%h exp 0", found, imem_addr);
    end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    mem_lat = 1;
    hold_reset();
    mem_quota = 5;
    release_reset();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      stall = (c == 3 || c == 4);
      @(negedge clk);
    end
    step();
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (perf_fetched !== 32'd5 || perf_stall !== 32'd2) begin
      n_fail++; $display("FAIL perf_counts got f=%0d s=%0d exp f=5 s=2", perf_fetched, perf_stall);
    end
    mem_quota = -1;
    repeat (6) step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL perf_reset got f=%0d s=%0d req=%b exp 0/0/0",
                         perf_fetched, perf_stall, imem_req);
    end
    repeat (2) step();
  endtask
`endif

  // Random stalls/redirects; decode must see consecutive PCs from the last redirect target.
  task automatic test_random();
    logic [63:0] exp_pc = 64'h0;
    logic [63:0] rpc;
    int consumed = 0;
    mem_lat = 0;
    mem_quota = -1;
    hold_reset();
    release_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        step();
        stall = ($urandom_range(0, 99) < 30);
        redirect = ($urandom_range(0, 99) < 4);
        if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
        else rpc = {48'h0, 16'($urandom)};
        redirect_pc = rpc;
      end
      @(negedge clk);
      if (imem_req && redirect) begin
        n_checks++;
        n_fail++; $display("FAIL rnd_req_in_redirect c=%0d got req=1 exp 0", c);
      end
      if (redirect) begin
        exp_pc = {redirect_pc[63:2], 2'b00};
      end else if (if_valid && !stall) begin
        n_checks++;
        if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_stream c=%0d got pc=%h i=%h exp pc=%h i=%h",
                             c, if_pc, if_instr, exp_pc, mem_word(exp_pc));
        end
        n_checks++;
        if (if_opcode !== mem_word(exp_pc) >> 21) begin
          n_fail++; $display("FAIL rnd_opcode c=%0d got=%h exp=%h", c, if_opcode,
                             mem_word(exp_pc) >> 21);
        end
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
    end
    step();
    stall = 1'b0;
    redirect = 1'b0;
    n_checks++;
    if (consumed < 300) begin
      n_fail++; $display("FAIL rnd_progress got=%0d exp>=300", consumed);
    end
    n_checks++;
    if (proto_err != 0) begin
      n_fail++; $display("FAIL one_outstanding got=%0d exp=0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_stall_skid();
    test_redirect_outstanding();
    test_redirect_rvalid();
    test_pc_wrap();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
